// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative EX-stage MULT/MULTU/DIV/DIVU unit producing one HI/LO write, with MTHI/MTLO pass-through
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             op_valid,
  input  logic             inst_mult,
  input  logic             inst_multu,
  input  logic             inst_div,
  input  logic             inst_divu,
  input  logic             inst_mthi,
  input  logic             inst_mtlo,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stallreq,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_q, neg_d, nrem_q, nrem_d;
  logic               is_md, is_div, sgn, live, in_done, mth, mtl;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] iter, prod;
  logic               unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1:0]};
  // One datapath iteration: shift-add for multiply, restoring shift-subtract for divide, plus final sign fix-up
  always_comb begin
    is_md    = op_valid & (inst_mult | inst_multu | inst_div | inst_divu);
    is_div   = inst_div | inst_divu;
    sgn      = inst_mult | inst_div;
    abs_a    = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b    = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, b_q};
    iter     = !div_q ? {mul_sum, acc_q[WIDTH-1:1]} :
               div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                 {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod     = neg_q ? -iter : iter;
    quo      = neg_q ? -iter[WIDTH-1:0] : iter[WIDTH-1:0];
    rem      = nrem_q ? -iter[2*WIDTH-1:WIDTH] : iter[2*WIDTH-1:WIDTH];
  end
  // Next-state: issue from IDLE, iterate in CALC, hold DONE until EX is released; cancel always wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cancel) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE && is_md && is_div && src_b == '0) begin
      state_d = S_DONE;
      hi_d    = src_a;
      lo_d    = '1;
    end else if (state_q == S_IDLE && is_md) begin
      state_d = S_CALC;
      cnt_d   = '0;
      acc_d   = {{WIDTH{1'b0}}, abs_a};
      b_d     = abs_b;
      div_d   = is_div;
      neg_d   = sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      nrem_d  = inst_div & src_a[WIDTH-1];
    end else if (state_q == S_CALC) begin
      acc_d = iter;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_DONE;
        hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo : prod[WIDTH-1:0];
      end
    end else if (state_q == S_DONE && !stall[2]) begin
      state_d = S_IDLE;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  // Outputs: result write in DONE, MTHI/MTLO pass-through in IDLE, everything silenced by rst or cancel
  always_comb begin
    live     = !rst && !cancel;
    in_done  = state_q == S_DONE;
    mth      = op_valid && inst_mthi && state_q == S_IDLE;
    mtl      = op_valid && inst_mtlo && state_q == S_IDLE;
    stallreq = live && (state_q == S_CALC || (state_q == S_IDLE && is_md));
    hi_we    = live && (in_done || mth);
    lo_we    = live && (in_done || mtl);
    hi_out   = !live ? '0 : in_done ? hi_q : mth ? src_a : '0;
    lo_out   = !live ? '0 : in_done ? lo_q : mtl ? src_a : '0;
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: table vectors, corner sequences and randomized ops against an arithmetic reference model
module tb_hilo_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        op_valid, inst_mult, inst_multu, inst_div, inst_divu, inst_mthi, inst_mtlo, cancel;
  logic [31:0] src_a, src_b;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;
  int n_vec = 0;
  int n_bad = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_valid(op_valid),
    .inst_mult(inst_mult), .inst_multu(inst_multu), .inst_div(inst_div), .inst_divu(inst_divu),
    .inst_mthi(inst_mthi), .inst_mtlo(inst_mtlo), .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          op;
    logic [31:0] a, b, hi, lo;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op);
    inst_mult  = (op == 0);
    inst_multu = (op == 1);
    inst_div   = (op == 2);
    inst_divu  = (op == 3);
  endtask

  task automatic idle_inputs;
    op_valid = 0;
    set_op(-1);
    inst_mthi = 0;
    inst_mtlo = 0;
    cancel = 0;
    stall = '0;
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend sign
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 0;
    lo = 0;
    if (op == 0) begin
      p = sa * sb;
      {hi, lo} = p;
    end else if (op == 1) begin
      u = {32'b0, a} * {32'b0, b};
      {hi, lo} = u;
    end else if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op == 2) begin
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Issue one op, count stall cycles, check the single DONE write, optionally hold DONE via stall[2]
  task automatic run_op(input string nm, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int hold);
    int cyc;
    op_valid = 1;
    set_op(op);
    src_a = a;
    src_b = b;
    cyc = 0;
    #1;
    while (stallreq && cyc < 100) begin
      cyc++;
      step;
    end
    chk({nm, " stall_cycles"}, 64'(cyc), (op >= 2 && b == 0) ? 64'd1 : 64'd33);
    chk({nm, " we"}, {hi_we, lo_we}, 2'b11);
    chk({nm, " hi"}, hi_out, eh);
    chk({nm, " lo"}, lo_out, el);
    if (hold > 0) begin
      stall = 6'b000100;
      repeat (hold) begin
        step;
        chk({nm, " hold"}, {stallreq, hi_we, lo_we, hi_out, lo_out}, {3'b011, eh, el});
      end
      stall = '0;
    end
    step;
    idle_inputs;
    #1;
    chk({nm, " idle_after"}, {stallreq, hi_we, lo_we}, 3'b000);
  endtask

  // Watch for any write or stall request over a window; none is allowed
  task automatic quiet(input string nm, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      step;
      if (stallreq || hi_we || lo_we) hits++;
    end
    chk({nm, " quiet"}, 64'(hits), 64'd0);
  endtask

  vec_t tv[7];
  logic [31:0] eh, el, ra, rb;
  int rop;

  initial begin
    tv[0] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    tv[1] = '{0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0};
    tv[2] = '{2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    tv[3] = '{3, 32'd7,         32'd2,         32'd1,         32'd3,         0};
    tv[4] = '{3, 32'h64,        32'd0,         32'h64,        32'hFFFF_FFFF, 0};
    tv[5] = '{2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 3};
    tv[6] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0};

    idle_inputs;
    src_a = 32'h5555;
    src_b = 0;
    rst = 1;
    op_valid = 1;
    inst_mthi = 1;
    step;
    step;
    chk("reset ctl", {stallreq, hi_we, lo_we}, 3'b000);
    chk("reset hi", hi_out, 0);
    chk("reset lo", lo_out, 0);
    rst = 0;
    idle_inputs;
    step;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].hold);

    op_valid = 1;
    inst_mthi = 1;
    src_a = 32'h1234;
    #1;
    chk("mthi ctl", {stallreq, hi_we, lo_we}, 3'b010);
    chk("mthi hi", hi_out, 32'h1234);
    chk("mthi lo", lo_out, 0);
    step;
    inst_mthi = 0;
    run_op("mult_after_mthi", 0, 32'd2, 32'd3, 32'd0, 32'd6, 0);
    op_valid = 1;
    inst_mtlo = 1;
    src_a = 32'hCAFE;
    #1;
    chk("mtlo", {stallreq, hi_we, lo_we, lo_out}, {3'b001, 32'hCAFE});
    step;
    idle_inputs;

    run_op("b2b_1", 0, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 0);
    run_op("b2b_2", 0, 32'd100, 32'd100, 32'd0, 32'd10000, 0);

    op_valid = 1;
    set_op(0);
    src_a = 32'd5;
    src_b = 32'd6;
    repeat (11) step;
    cancel = 1;
    #1;
    chk("cancel ctl", {stallreq, hi_we, lo_we}, 3'b000);
    step;
    idle_inputs;
    quiet("cancel", 40);

    op_valid = 1;
    set_op(1);
    src_a = 32'd11;
    src_b = 32'd13;
    repeat (5) step;
    rst = 1;
    #1;
    chk("rst_mid ctl", {stallreq, hi_we, lo_we}, 3'b000);
    chk("rst_mid out", {hi_out, lo_out}, 64'd0);
    step;
    rst = 0;
    idle_inputs;
    quiet("rst_mid", 40);
    run_op("after_rst", 0, 32'd9, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFDC, 0);

    for (int i = 0; i < 40; i++) begin
      rop = int'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 8 == 7) ra = -ra;
      model(rop, ra, rb, eh, el);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eh, el, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
